cla_error_monitor: RTL and testbench

//  Receiving end of the adder test path. Samples operands and the approximate adder's SUM/COUT,

---
 rtl/cla_error_monitor.sv | 169 ++++++++++++++++
 tb/tb_cla_error_monitor.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cla_error_monitor
// Description : Receiving end of an adder test path. Samples the operands and
//               the approximate SUM/COUT of an adder under test, recomputes
//               the exact A+B+CIN and accumulates error statistics over a
//               programmed number of samples.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - 1-cycle pulse: clear stats, latch n_samples
//               n_samples       - samples to accept in this run
//               in_valid        - a/b/cin/sum/cout valid this cycle
//               a, b, cin       - operands applied to the adder under test
//               sum, cout       - approximate result from the adder under test
//               busy, done      - run in progress / run complete
//               err_pulse       - 1-cycle pulse when a retiring sample mismatches
//               sample_cnt      - samples retired this run
//               err_cnt         - retired samples with exact != approx
//               err_sum         - saturating sum of error distances
//               max_ed          - largest error distance seen this run
// Revision    : 1.0 - initial release
// ============================================================================
module cla_error_monitor #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
  input  logic             cin,
  input  logic [SIZE-1:0]  sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             err_pulse,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [SIZE:0]    max_ed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] accepted;
  logic             launch;
  logic             accept;
  logic             last_accept;

  // Stage 1: exact and approximate results of the accepted sample
  logic             s1_valid;
  logic [SIZE:0]    s1_exact;
  logic [SIZE:0]    s1_approx;

  // Stage 2: error distance of the sample about to retire
  logic             s2_valid;
  logic             s2_mis;
  logic [SIZE:0]    s2_ed;

  logic [SIZE:0]    ed_next;
  logic [ACC_W:0]   ed_ext;
  logic [ACC_W:0]   sum_ext;

  // START only launches a run from IDLE or DONE; mid-run pulses are dropped.
  assign launch      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept      = (state == ST_RUN) && in_valid && (accepted < n_lat);
  assign last_accept = accept && ((accepted + CNT_W'(1)) == n_lat);

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if ((n_lat == '0) || last_accept) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Nothing is accepted in DRAIN, so once stage 1 is empty the sample in
        // stage 2 (if any) retires on this edge and the pipeline is empty.
        if (!s1_valid) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ed_next = (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                      : (s1_approx - s1_exact);
    ed_ext          = '0;
    ed_ext[SIZE:0]  = s2_ed;
    // One extra bit catches the overflow that drives saturation.
    sum_ext         = {1'b0, err_sum} + ed_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat      <= '0;
      accepted   <= '0;
      s1_valid   <= 1'b0;
      s1_exact   <= '0;
      s1_approx  <= '0;
      s2_valid   <= 1'b0;
      s2_mis     <= 1'b0;
      s2_ed      <= '0;
      err_pulse  <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
      max_ed     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exact  <= {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
        s1_approx <= {cout, sum};
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ed  <= ed_next;
        s2_mis <= (ed_next != '0);
      end

      err_pulse <= s2_valid && s2_mis;

      if (launch) begin
        n_lat      <= n_samples;
        accepted   <= '0;
        sample_cnt <= '0;
        err_cnt    <= '0;
        err_sum    <= '0;
        max_ed     <= '0;
      end else begin
        if (accept) accepted <= accepted + CNT_W'(1);
        if (s2_valid) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          if (s2_mis) err_cnt <= err_cnt + CNT_W'(1);
          err_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
          if (s2_ed > max_ed) max_ed <= s2_ed;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_error_monitor
// Description : Self-checking bench for cla_error_monitor. A transaction-level
//               reference model tracks accepted samples and the statistics
//               they must produce two edges later. A second instance with a
//               17-bit accumulator shares the stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_error_monitor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, cin, cout;
  logic [15:0] n_samples, a, b, sum;

  logic        busy, done, err_pulse;
  logic [15:0] sample_cnt, err_cnt;
  logic [31:0] err_sum;
  logic [16:0] max_ed;

  logic        busy17, done17, err_pulse17;
  logic [15:0] sample_cnt17, err_cnt17;
  logic [16:0] err_sum17, max_ed17;

  cla_error_monitor #(.SIZE(16), .CNT_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .err_pulse(err_pulse), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .err_sum(err_sum), .max_ed(max_ed)
  );

  cla_error_monitor #(.SIZE(16), .CNT_W(16), .ACC_W(17)) dut17 (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy17), .done(done17), .err_pulse(err_pulse17), .sample_cnt(sample_cnt17),
    .err_cnt(err_cnt17), .err_sum(err_sum17), .max_ed(max_ed17)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit     m_run, m_active;
  int     m_n, m_acc, m_cnt, m_err, m_max;
  longint m_sum, m_sum17;
  bit     p_v[2];
  int     p_ed[2];

  // One clock edge: the model decides what the edge accepts, then after the
  // edge retires the sample accepted two edges earlier and compares stats.
  task automatic tick();
    bit acc_now;
    bit exp_pulse;
    int ed, exact, approx;
    acc_now = 1'b0;
    ed      = 0;
    if (rst) begin
      m_run = 0; m_active = 0; m_n = 0; m_acc = 0;
      m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0; m_sum17 = 0;
      p_v[0] = 0; p_v[1] = 0; p_ed[0] = 0; p_ed[1] = 0;
    end else begin
      acc_now = m_run && in_valid && (m_acc < m_n);
      if (acc_now) begin
        exact  = int'(a) + int'(b) + int'(cin);
        approx = int'(cout) * 65536 + int'(sum);
        ed     = (exact > approx) ? exact - approx : approx - exact;
        m_acc++;
        if (m_acc == m_n) m_run = 0;
      end
      if (start && !m_active) begin
        m_n = int'(n_samples); m_acc = 0; m_run = (m_n != 0); m_active = 1;
        m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0; m_sum17 = 0;
      end
    end
    @(posedge clk);
    #1;
    exp_pulse = 1'b0;
    if (p_v[1]) begin
      m_cnt++;
      if (p_ed[1] != 0) begin m_err++; exp_pulse = 1'b1; end
      m_sum   = m_sum + p_ed[1];
      m_sum17 = m_sum17 + p_ed[1];
      if (m_sum > 64'd4294967295) m_sum = 64'd4294967295;
      if (m_sum17 > 64'd131071) m_sum17 = 64'd131071;
      if (p_ed[1] > m_max) m_max = p_ed[1];
    end
    p_v[1] = p_v[0]; p_ed[1] = p_ed[0];
    p_v[0] = acc_now; p_ed[0] = ed;
    if (m_active && !m_run && !p_v[0] && !p_v[1]) m_active = 0;

    checks++;
    if (err_pulse !== exp_pulse) begin
      errors++; $display("FAIL err_pulse @%0t: got %0b expected %0b", $time, err_pulse, exp_pulse);
    end
    checks++;
    if (sample_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL sample_cnt @%0t: got %0d expected %0d", $time, sample_cnt, m_cnt);
    end
    checks++;
    if (err_cnt !== 16'(m_err)) begin
      errors++; $display("FAIL err_cnt @%0t: got %0d expected %0d", $time, err_cnt, m_err);
    end
    checks++;
    if (err_sum !== 32'(m_sum)) begin
      errors++; $display("FAIL err_sum @%0t: got %0d expected %0d", $time, err_sum, m_sum);
    end
    checks++;
    if (max_ed !== 17'(m_max)) begin
      errors++; $display("FAIL max_ed @%0t: got %0d expected %0d", $time, max_ed, m_max);
    end
    checks++;
    if (err_sum17 !== 17'(m_sum17)) begin
      errors++; $display("FAIL err_sum17 @%0t: got %0d expected %0d", $time, err_sum17, m_sum17);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input int n);
    start = 1'b1; n_samples = 16'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic [15:0] xs, input logic xco);
    a = xa; b = xb; cin = xc; sum = xs; cout = xco; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_samples = '0;
    a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
    idle(2);
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_state: busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_exact_match();
    do_start(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL match_busy: got %0b expected 1", busy); end
    send(16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL match_done_early: done=%0b busy=%0b expected 0 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL match_done: done=%0b busy=%0b expected 1 0", done, busy);
    end
    checks++;
    if (sample_cnt !== 16'd1 || err_cnt !== 16'd0 || err_sum !== 32'd0 || max_ed !== 17'd0) begin
      errors++; $display("FAIL match_stats: cnt=%0d err=%0d sum=%0d max=%0d expected 1 0 0 0",
                         sample_cnt, err_cnt, err_sum, max_ed);
    end
  endtask

  task automatic test_max_error();
    do_start(1);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    checks++;
    if (err_pulse !== 1'b1) begin errors++; $display("FAIL max_pulse: got %0b expected 1", err_pulse); end
    checks++;
    if (err_cnt !== 16'd1 || err_sum !== 32'd65536 || max_ed !== 17'h10000 || done !== 1'b1) begin
      errors++; $display("FAIL max_stats: err=%0d sum=%0d max=%h done=%0b expected 1 65536 10000 1",
                         err_cnt, err_sum, max_ed, done);
    end
    tick();
  endtask

  task automatic test_gaps();
    do_start(3);
    send(16'd100, 16'd0, 1'b0, 16'd105, 1'b0);
    idle(2);
    send(16'd7, 16'd8, 1'b1, 16'd16, 1'b0);
    idle(1);
    send(16'd50, 16'd50, 1'b0, 16'd88, 1'b0);
    send(16'd1, 16'd1, 1'b0, 16'd900, 1'b0);
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %0b expected 1", done); end
    checks++;
    if (sample_cnt !== 16'd3 || err_cnt !== 16'd2 || err_sum !== 32'd17 || max_ed !== 17'd12) begin
      errors++; $display("FAIL gaps_stats: cnt=%0d err=%0d sum=%0d max=%0d expected 3 2 17 12",
                         sample_cnt, err_cnt, err_sum, max_ed);
    end
    send(16'd3, 16'd3, 1'b0, 16'd0, 1'b1);
    idle(2);
  endtask

  task automatic test_saturation();
    do_start(2);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    idle(2);
    checks++;
    if (err_sum17 !== 17'h1FFFF || err_cnt17 !== 16'd2 || err_sum !== 32'd131072) begin
      errors++; $display("FAIL saturation: sum17=%h err17=%0d sum32=%0d expected 1ffff 2 131072",
                         err_sum17, err_cnt17, err_sum);
    end
  endtask

  task automatic test_abort_reset();
    do_start(4);
    send(16'd10, 16'd10, 1'b0, 16'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_cnt !== 16'd0 || err_sum !== 32'd0) begin
      errors++; $display("FAIL abort_state: busy=%0b done=%0b cnt=%0d sum=%0d expected 0 0 0 0",
                         busy, done, sample_cnt, err_sum);
    end
    for (int i = 0; i < 3; i++) send(16'd5, 16'd5, 1'b0, 16'd1, 1'b0);
    idle(3);
    checks++;
    if (busy !== 1'b0 || sample_cnt !== 16'd0) begin
      errors++; $display("FAIL abort_ignore: busy=%0b cnt=%0d expected 0 0", busy, sample_cnt);
    end
  endtask

  task automatic test_zero_and_start_ignored();
    do_start(0);
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    checks++;
    if (done !== 1'b1 || sample_cnt !== 16'd0 || max_ed !== 17'd0) begin
      errors++; $display("FAIL zero_run: done=%0b cnt=%0d max=%0d expected 1 0 0", done, sample_cnt, max_ed);
    end
    do_start(2);
    send(16'd20, 16'd1, 1'b0, 16'd25, 1'b0);
    start = 1'b1; n_samples = 16'd5;
    tick();
    start = 1'b0;
    send(16'd2, 16'd2, 1'b0, 16'd4, 1'b0);
    idle(2);
    checks++;
    if (done !== 1'b1 || sample_cnt !== 16'd2) begin
      errors++; $display("FAIL start_ignored: done=%0b cnt=%0d expected 1 2", done, sample_cnt);
    end
  endtask

  task automatic test_random();
    int n, cyc, ex, ap;
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(3, 12));
      do_start(n);
      cyc = 0;
      while (m_run && cyc < 300) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
        ex = int'(a) + int'(b) + int'(cin);
        case ($urandom_range(0, 3))
          0: ap = ex;
          1: ap = ex + int'($urandom_range(0, 40));
          2: ap = ex - int'($urandom_range(0, 40));
          default: ap = int'($urandom_range(0, 131071));
        endcase
        if (ap < 0) ap = 0;
        if (ap > 131071) ap = 131071;
        sum = ap[15:0]; cout = ap[16];
        in_valid = ($urandom_range(0, 9) < 7);
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (done === 1'b1) break;
        tick();
      end
      checks++;
      if (done !== 1'b1 || sample_cnt !== 16'(n)) begin
        errors++; $display("FAIL random_run%0d: done=%0b cnt=%0d expected 1 %0d", r, done, sample_cnt, n);
      end
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_max_error();
    test_gaps();
    test_saturation();
    test_abort_reset();
    test_zero_and_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
